// File: rtl/spi_bus_arbiter.sv
// Two-port SPI bus arbiter: round-robin grant with guard gaps,
// registered mux outputs and a hold watchdog.
module spi_bus_arbiter #(
  parameter logic        CK_IDLE      = 1'b0,
  parameter int unsigned GUARD_CYCLES = 4,
  parameter int unsigned MAX_HOLD     = 0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_spi_ck0,
  input  logic i_spi_ck1,
  input  logic i_spi_mosi0,
  input  logic i_spi_mosi1,
  output logic o_grant0,
  output logic o_grant1,
  output logic o_sel,
  output logic o_spi_ck,
  output logic o_spi_mosi,
  output logic o_busy,
  output logic o_timeout
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SWITCH,
    S_GRANT,
    S_GUARD
  } state_t;

  localparam logic [7:0]  GUARD_LD = 8'(GUARD_CYCLES);
  localparam logic [23:0] HOLD_LIM = 24'(MAX_HOLD - 1);
  localparam logic        WD_EN    = (MAX_HOLD != 0);

  state_t      r_state;
  logic        r_sel;
  logic        r_last;
  logic [1:0]  r_lock;
  logic [7:0]  r_gcnt;
  logic [23:0] r_hcnt;
  logic        r_grant0;
  logic        r_grant1;
  logic        r_ck;
  logic        r_mosi;
  logic        r_busy;
  logic        r_to;

  state_t      w_state_n;
  logic        w_sel_n;
  logic        w_last_n;
  logic [1:0]  w_lock_n;
  logic [7:0]  w_gcnt_n;
  logic [23:0] w_hcnt_n;
  logic        w_to_n;
  logic [1:0]  w_req;
  logic [1:0]  w_elig;
  logic        w_win;
  logic        w_req_sel;
  logic        w_gnt_n;
  logic        w_ck_n;
  logic        w_mosi_n;

  assign w_req     = {i_req1, i_req0};
  assign w_elig    = w_req & ~r_lock;
  assign w_req_sel = r_sel ? i_req1 : i_req0;
  // On a tie the port that did not own the bus last wins.
  assign w_win     = (w_elig == 2'b11) ? ~r_last : w_elig[1];

  always_comb begin
    w_state_n = r_state;
    w_sel_n   = r_sel;
    w_last_n  = r_last;
    w_lock_n  = r_lock & w_req;
    w_gcnt_n  = r_gcnt;
    w_hcnt_n  = r_hcnt;
    w_to_n    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|w_elig) begin
          if (w_win == r_sel) begin
            w_state_n = S_GRANT;
            w_hcnt_n  = '0;
          end else begin
            w_sel_n   = w_win;
            w_gcnt_n  = GUARD_LD;
            w_state_n = S_SWITCH;
          end
        end
      end
      S_SWITCH: begin
        if (r_gcnt <= 8'd1) begin
          w_state_n = S_GRANT;
          w_hcnt_n  = '0;
        end else begin
          w_gcnt_n = r_gcnt - 8'd1;
        end
      end
      S_GRANT: begin
        if (!w_req_sel) begin
          w_last_n  = r_sel;
          w_gcnt_n  = GUARD_LD;
          w_state_n = S_GUARD;
        end else if (WD_EN && (r_hcnt == HOLD_LIM)) begin
          w_to_n          = 1'b1;
          w_lock_n[r_sel] = 1'b1;
          w_last_n        = r_sel;
          w_gcnt_n        = GUARD_LD;
          w_state_n       = S_GUARD;
        end else if (r_hcnt != '1) begin
          w_hcnt_n = r_hcnt + 24'd1;
        end
      end
      S_GUARD: begin
        if (r_gcnt <= 8'd1) begin
          w_state_n = S_IDLE;
        end else begin
          w_gcnt_n = r_gcnt - 8'd1;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  // Mux follows the next state so the bus parks on the same edge
  // the grant drops.
  always_comb begin
    w_gnt_n  = (w_state_n == S_GRANT);
    w_ck_n   = CK_IDLE;
    w_mosi_n = 1'b0;
    if (w_gnt_n) begin
      w_ck_n   = w_sel_n ? i_spi_ck1 : i_spi_ck0;
      w_mosi_n = w_sel_n ? i_spi_mosi1 : i_spi_mosi0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_sel    <= 1'b0;
      r_last   <= 1'b1;
      r_lock   <= 2'b00;
      r_gcnt   <= '0;
      r_hcnt   <= '0;
      r_grant0 <= 1'b0;
      r_grant1 <= 1'b0;
      r_ck     <= CK_IDLE;
      r_mosi   <= 1'b0;
      r_busy   <= 1'b0;
      r_to     <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_sel    <= w_sel_n;
      r_last   <= w_last_n;
      r_lock   <= w_lock_n;
      r_gcnt   <= w_gcnt_n;
      r_hcnt   <= w_hcnt_n;
      r_grant0 <= w_gnt_n & ~w_sel_n;
      r_grant1 <= w_gnt_n & w_sel_n;
      r_ck     <= w_ck_n;
      r_mosi   <= w_mosi_n;
      r_busy   <= (w_state_n != S_IDLE);
      r_to     <= w_to_n;
    end
  end

  assign o_grant0   = r_grant0;
  assign o_grant1   = r_grant1;
  assign o_sel      = r_sel;
  assign o_spi_ck   = r_ck;
  assign o_spi_mosi = r_mosi;
  assign o_busy     = r_busy;
  assign o_timeout  = r_to;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Bench for spi_bus_arbiter: edge-indexed vector tables feeding
// a scoreboard of expected output snapshots.
module tb_spi_bus_arbiter;

  logic clk = 1'b0;
  logic rst_n, req0, req1, ck0, ck1, mosi0, mosi1;

  logic a_g0, a_g1, a_sel, a_ck, a_mosi, a_busy, a_to;
  logic b_g0, b_g1, b_sel, b_ck, b_mosi, b_busy, b_to;
  logic c_g0, c_g1, c_sel, c_ck, c_mosi, c_busy, c_to;

  int checks = 0;
  int failures = 0;
  logic mon_en = 1'b0;

  always #5 clk = ~clk;

  spi_bus_arbiter #(.CK_IDLE(1'b0), .GUARD_CYCLES(4), .MAX_HOLD(0)) u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_req0(req0), .i_req1(req1),
    .i_spi_ck0(ck0), .i_spi_ck1(ck1),
    .i_spi_mosi0(mosi0), .i_spi_mosi1(mosi1),
    .o_grant0(a_g0), .o_grant1(a_g1), .o_sel(a_sel),
    .o_spi_ck(a_ck), .o_spi_mosi(a_mosi),
    .o_busy(a_busy), .o_timeout(a_to)
  );

  spi_bus_arbiter #(.CK_IDLE(1'b1), .GUARD_CYCLES(4), .MAX_HOLD(0)) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_req0(req0), .i_req1(req1),
    .i_spi_ck0(ck0), .i_spi_ck1(ck1),
    .i_spi_mosi0(mosi0), .i_spi_mosi1(mosi1),
    .o_grant0(b_g0), .o_grant1(b_g1), .o_sel(b_sel),
    .o_spi_ck(b_ck), .o_spi_mosi(b_mosi),
    .o_busy(b_busy), .o_timeout(b_to)
  );

  spi_bus_arbiter #(.CK_IDLE(1'b0), .GUARD_CYCLES(4), .MAX_HOLD(16)) u_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_req0(req0), .i_req1(req1),
    .i_spi_ck0(ck0), .i_spi_ck1(ck1),
    .i_spi_mosi0(mosi0), .i_spi_mosi1(mosi1),
    .o_grant0(c_g0), .o_grant1(c_g1), .o_sel(c_sel),
    .o_spi_ck(c_ck), .o_spi_mosi(c_mosi),
    .o_busy(c_busy), .o_timeout(c_to)
  );

  // in  = {rst_n, req0, req1, ck0, ck1, mosi0, mosi1}
  // exp = {g0, g1, sel, busy, timeout, ck, ck_of_idle1_dut, mosi}
  typedef struct {
    string      nm;
    int         e;
    logic [6:0] in;
    int         ce;
    logic [7:0] exp;
    logic [7:0] msk;
    logic       dsel;
  } vec_t;

  typedef struct {
    string      nm;
    int         ce;
    logic [7:0] exp;
    logic [7:0] msk;
    logic       dsel;
  } chk_t;

  localparam logic [7:0] ALL   = 8'hFF;
  localparam logic [7:0] NOCKB = 8'hFD;

  vec_t tbl[$];
  chk_t sb[$];

  function automatic vec_t mk(string nm, int e, logic [6:0] in, int ce,
                              logic [7:0] exp, logic [7:0] msk,
                              logic dsel);
    vec_t v;
    v.nm = nm; v.e = e; v.in = in; v.ce = ce;
    v.exp = exp; v.msk = msk; v.dsel = dsel;
    return v;
  endfunction

  function automatic logic [7:0] obs(logic dsel);
    if (dsel)
      return {c_g0, c_g1, c_sel, c_busy, c_to, c_ck, b_ck, c_mosi};
    return {a_g0, a_g1, a_sel, a_busy, a_to, a_ck, b_ck, a_mosi};
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if ((a_g0 && a_g1) || (c_g0 && c_g1)) begin
        failures++;
        $display("FAIL excl t=%0t got a=%b%b c=%b%b want no double grant",
                 $time, a_g0, a_g1, c_g0, c_g1);
      end
    end
  end

  task automatic run(input int last);
    int   idx;
    chk_t c;
    logic [7:0] got;
    idx = 0;
    {rst_n, req0, req1, ck0, ck1, mosi0, mosi1} = 7'b0;
    for (int e = 0; e <= last; e++) begin
      @(posedge clk);
      #1;
      while (idx < tbl.size() && tbl[idx].e == e) begin
        {rst_n, req0, req1, ck0, ck1, mosi0, mosi1} = tbl[idx].in;
        if (tbl[idx].ce >= 0) begin
          c.nm = tbl[idx].nm; c.ce = tbl[idx].ce;
          c.exp = tbl[idx].exp; c.msk = tbl[idx].msk;
          c.dsel = tbl[idx].dsel;
          sb.push_back(c);
        end
        idx++;
      end
      for (int k = sb.size() - 1; k >= 0; k--) begin
        if (sb[k].ce == e) begin
          got = obs(sb[k].dsel);
          checks++;
          if ((got & sb[k].msk) !== (sb[k].exp & sb[k].msk)) begin
            failures++;
            $display("FAIL %s edge=%0d got=%b want=%b mask=%b",
                     sb[k].nm, e, got, sb[k].exp, sb[k].msk);
          end
          sb.delete(k);
        end
      end
    end
    while (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL %s never reached got=none want=%b",
               sb[0].nm, sb[0].exp);
      sb.delete(0);
    end
    tbl.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=stall want=finish");
    $fatal(1, "bench stalled");
  end

  initial begin
    {rst_n, req0, req1, ck0, ck1, mosi0, mosi1} = 7'b0;
    mon_en = 1'b1;

    // single request on port 0
    tbl.push_back(mk("s1_rst",    0, 7'b1_00_00_00,  0, 8'b0000_0010, ALL, 0));
    tbl.push_back(mk("s1_idle",  10, 7'b1_10_00_00, 10, 8'b0000_0010, ALL, 0));
    tbl.push_back(mk("s1_gnt",   11, 7'b1_10_00_00, 11, 8'b1001_0000, ALL, 0));
    tbl.push_back(mk("s1_lag0",  12, 7'b1_10_10_10, 12, 8'b1001_0000, ALL, 0));
    tbl.push_back(mk("s1_lag1",  13, 7'b1_10_10_10, 13, 8'b1001_0111, ALL, 0));
    tbl.push_back(mk("s1_lo",    14, 7'b1_10_00_00, 15, 8'b1001_0000, ALL, 0));
    tbl.push_back(mk("s1_hi",    20, 7'b1_10_10_10, 21, 8'b1001_0111, ALL, 0));
    tbl.push_back(mk("s1_hold",  30, 7'b1_00_10_10, 30, 8'b1001_0111, ALL, 0));
    tbl.push_back(mk("s1_rel",   31, 7'b1_00_10_10, 31, 8'b0001_0010, ALL, 0));
    tbl.push_back(mk("s1_guard", 34, 7'b1_00_10_10, 34, 8'b0001_0010, ALL, 0));
    tbl.push_back(mk("s1_done",  36, 7'b1_00_10_10, 36, 8'b0000_0010, ALL, 0));
    run(37);

    // port 1 alone: select switch with guard, ck1 toggling
    tbl.push_back(mk("s2_go",     0, 7'b1_00_00_00, -1, 8'b0,         ALL, 0));
    tbl.push_back(mk("s2_req",   10, 7'b1_01_00_00, -1, 8'b0,         ALL, 0));
    tbl.push_back(mk("s2_sel",   11, 7'b1_01_01_00, 11, 8'b0011_0010, ALL, 0));
    tbl.push_back(mk("s2_sw12",  12, 7'b1_01_00_00, 12, 8'b0011_0010, ALL, 0));
    tbl.push_back(mk("s2_sw13",  13, 7'b1_01_01_00, 13, 8'b0011_0010, ALL, 0));
    tbl.push_back(mk("s2_park",  14, 7'b1_01_00_00, 14, 8'b0011_0010, ALL, 0));
    tbl.push_back(mk("s2_gnt",   15, 7'b1_01_01_00, 15, 8'b0111_0000, ALL, 0));
    tbl.push_back(mk("s2_lag",   16, 7'b1_01_00_00, 16, 8'b0111_0110, ALL, 0));
    tbl.push_back(mk("s2_hold",  18, 7'b1_00_00_00, 18, 8'b0111_0000, ALL, 0));
    tbl.push_back(mk("s2_guard", 19, 7'b1_00_00_00, 19, 8'b0011_0010, ALL, 0));
    tbl.push_back(mk("s2_gend",  22, 7'b1_00_00_00, 22, 8'b0011_0010, ALL, 0));
    tbl.push_back(mk("s2_idle",  23, 7'b1_00_00_00, 23, 8'b0010_0010, ALL, 0));
    run(24);

    // three ties: expected owners 0, 1, 0
    tbl.push_back(mk("s3_go",     0, 7'b1_00_00_00, -1, 8'b0,         ALL, 0));
    tbl.push_back(mk("s3_t1",    10, 7'b1_11_00_00, 11, 8'b1001_0000, ALL, 0));
    tbl.push_back(mk("s3_g1",    18, 7'b1_00_00_00, 19, 8'b0001_0010, ALL, 0));
    tbl.push_back(mk("s3_t2sw",  24, 7'b1_11_00_00, 25, 8'b0011_0010, ALL, 0));
    tbl.push_back(mk("s3_t2",    29, 7'b1_11_00_00, 29, 8'b0111_0000, ALL, 0));
    tbl.push_back(mk("s3_g2",    36, 7'b1_00_00_00, 37, 8'b0011_0010, ALL, 0));
    tbl.push_back(mk("s3_t3sw",  42, 7'b1_11_00_00, 43, 8'b0001_0010, ALL, 0));
    tbl.push_back(mk("s3_t3",    47, 7'b1_11_00_00, 47, 8'b1001_0000, ALL, 0));
    tbl.push_back(mk("s3_end",   54, 7'b1_00_00_00, 59, 8'b0000_0010, ALL, 0));
    run(60);

    // watchdog on the MAX_HOLD=16 instance
    tbl.push_back(mk("s4_rst",    0, 7'b1_00_00_00,  0, 8'b0000_0000, NOCKB, 1));
    tbl.push_back(mk("s4_gnt",   10, 7'b1_10_00_00, 11, 8'b1001_0000, NOCKB, 1));
    tbl.push_back(mk("s4_last",  20, 7'b1_11_00_00, 26, 8'b1001_0000, NOCKB, 1));
    tbl.push_back(mk("s4_to",    27, 7'b1_11_00_00, 27, 8'b0001_1000, NOCKB, 1));
    tbl.push_back(mk("s4_to1",   28, 7'b1_11_00_00, 28, 8'b0001_0000, NOCKB, 1));
    tbl.push_back(mk("s4_sw1",   32, 7'b1_11_00_00, 32, 8'b0011_0000, NOCKB, 1));
    tbl.push_back(mk("s4_g1",    36, 7'b1_11_00_00, 36, 8'b0111_0000, NOCKB, 1));
    tbl.push_back(mk("s4_idle",  40, 7'b1_10_00_00, 45, 8'b0010_0000, NOCKB, 1));
    tbl.push_back(mk("s4_lock",  50, 7'b1_00_00_00, 50, 8'b0010_0000, NOCKB, 1));
    tbl.push_back(mk("s4_sw0",   51, 7'b1_10_00_00, 52, 8'b0001_0000, NOCKB, 1));
    tbl.push_back(mk("s4_regnt", 56, 7'b1_10_00_00, 56, 8'b1001_0000, NOCKB, 1));
    run(57);

    // reset while port 1 owns the bus with ck1 high
    tbl.push_back(mk("s5_go",     0, 7'b1_00_00_00, -1, 8'b0,         ALL, 0));
    tbl.push_back(mk("s5_gnt",   10, 7'b1_01_01_01, 15, 8'b0111_0111, ALL, 0));
    tbl.push_back(mk("s5_rst",   16, 7'b0_01_01_01, 17, 8'b0000_0010, ALL, 0));
    tbl.push_back(mk("s5_rereq", 17, 7'b1_01_01_01, 18, 8'b0011_0010, ALL, 0));
    run(19);

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
